// File: rtl/nn_pkg.sv
// Shared constants, FSM state type and the accumulator-to-activation conversion
// used by the hidden layer and the output neuron.
package nn_pkg;

  localparam int N_IN   = 4;
  localparam int N_HID  = 8;
  localparam int FEAT_W = 4;
  localparam int W_W    = 8;
  localparam int X_W    = 10;
  localparam int ACC_W  = 14;
  localparam int SHIFT  = 3;
  localparam int N_W    = N_IN * N_HID;
  localparam int STEP_W = 5;

  typedef enum logic {IDLE, RUN} state_t;

  // Drop the 3 extra fraction bits, then clamp to the 10-bit activation range.
  function automatic logic [X_W-1:0] sat_shift(input logic [ACC_W-1:0] acc);
    logic [ACC_W-SHIFT-1:0] v;
    v = acc[ACC_W-1:SHIFT];
    if (|v[ACC_W-SHIFT-1:X_W]) return '1;
    return v[X_W-1:0];
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Feature x weight multiply into a registered accumulator.
// sum_o shows the accumulator value this cycle's product would produce.
module mac_unit
  import nn_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [FEAT_W-1:0] a_i,
  input  logic [W_W-1:0]    b_i,
  output logic [ACC_W-1:0]  sum_o
);

  logic [FEAT_W+W_W-1:0] prod;
  logic [ACC_W-1:0]      acc_q;

  assign prod  = a_i * b_i;
  assign sum_o = acc_q + ACC_W'(prod);

  // Clear wins over enable so a neuron's last step leaves a fresh accumulator.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)     acc_q <= '0;
    else if (clr_i) acc_q <= '0;
    else if (en_i)  acc_q <= sum_o;
  end

endmodule

// File: rtl/hidden_layer_seq.sv
// Eight hidden neurons computed one MAC per cycle over 32 steps. Results are
// staged in working registers and published together with a done pulse.
module hidden_layer_seq
  import nn_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [N_IN*FEAT_W-1:0] feat_i,
  input  logic                  wr_en_i,
  input  logic [STEP_W-1:0]     wr_addr_i,
  input  logic [W_W-1:0]        wr_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [X_W-1:0]        x0_o,
  output logic [X_W-1:0]        x1_o,
  output logic [X_W-1:0]        x2_o,
  output logic [X_W-1:0]        x3_o,
  output logic [X_W-1:0]        x4_o,
  output logic [X_W-1:0]        x5_o,
  output logic [X_W-1:0]        x6_o,
  output logic [X_W-1:0]        x7_o
);

  state_t                  state;
  logic [STEP_W-1:0]       step;
  logic [N_IN*FEAT_W-1:0]  feat_q;
  logic [W_W-1:0]          w_bank [N_W];
  logic [X_W-1:0]          xw     [N_HID];
  logic [X_W-1:0]          x_q    [N_HID];
  logic                    busy_q;
  logic                    done_q;

  logic [1:0]              k;
  logic [2:0]              j;
  logic                    mac_clr;
  logic                    mac_en;
  logic [FEAT_W-1:0]       mac_a;
  logic [ACC_W-1:0]        mac_sum;
  logic [X_W-1:0]          x_new;

  assign k       = step[1:0];
  assign j       = step[4:2];
  assign mac_clr = ((state == IDLE) && start_i) || ((state == RUN) && (k == 2'd3));
  assign mac_en  = (state == RUN);
  assign mac_a   = feat_q[{k, 2'b00} +: FEAT_W];
  assign x_new   = sat_shift(mac_sum);

  mac_unit u_mac (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (mac_a),
    .b_i   (w_bank[step]),
    .sum_o (mac_sum)
  );

  // Writes only land while idle; a run never sees its weights change.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < N_W; i++) w_bank[i] <= '0;
    end else if ((state == IDLE) && wr_en_i) begin
      w_bank[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      step   <= '0;
      feat_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < N_HID; i++) begin
        xw[i]  <= '0;
        x_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state  <= RUN;
            busy_q <= 1'b1;
            feat_q <= feat_i;
            step   <= '0;
          end
        end
        RUN: begin
          step <= step + 5'd1;
          if (k == 2'd3) xw[j] <= x_new;
          // Neuron 7 finishes on the same edge, so it bypasses its working register.
          if (step == 5'd31) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            for (int i = 0; i < N_HID - 1; i++) x_q[i] <= xw[i];
            x_q[N_HID-1] <= x_new;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign x0_o   = x_q[0];
  assign x1_o   = x_q[1];
  assign x2_o   = x_q[2];
  assign x3_o   = x_q[3];
  assign x4_o   = x_q[4];
  assign x5_o   = x_q[5];
  assign x6_o   = x_q[6];
  assign x7_o   = x_q[7];

endmodule

// File: tb/tb_hidden_layer_seq.sv
// Directed bench for hidden_layer_seq: latency, conversion and saturation,
// write/start interlocks and mid-run reset.
module tb_hidden_layer_seq;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [15:0] feat_i;
  logic        wr_en_i;
  logic [4:0]  wr_addr_i;
  logic [7:0]  wr_data_i;
  logic        busy_o;
  logic        done_o;
  logic [9:0]  x0, x1, x2, x3, x4, x5, x6, x7;
  logic [9:0]  x_obs [8];

  int checks = 0;
  int errors = 0;

  hidden_layer_seq dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .feat_i    (feat_i),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .x0_o      (x0),
    .x1_o      (x1),
    .x2_o      (x2),
    .x3_o      (x3),
    .x4_o      (x4),
    .x5_o      (x5),
    .x6_o      (x6),
    .x7_o      (x7)
  );

  assign x_obs[0] = x0;
  assign x_obs[1] = x1;
  assign x_obs[2] = x2;
  assign x_obs[3] = x3;
  assign x_obs[4] = x4;
  assign x_obs[5] = x5;
  assign x_obs[6] = x6;
  assign x_obs[7] = x7;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic write_w(input logic [4:0] addr, input logic [7:0] data);
    wr_en_i   = 1'b1;
    wr_addr_i = addr;
    wr_data_i = data;
    @(negedge clk_i);
    wr_en_i   = 1'b0;
  endtask

  task automatic write_all(input logic [7:0] data);
    for (int a = 0; a < 32; a++) write_w(5'(a), data);
  endtask

  // Pulses start for one edge and returns cycles until done_o is seen (40 = timeout).
  task automatic run_once(input logic [15:0] feat, output int lat);
    feat_i  = feat;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    lat = 0;
    while (done_o !== 1'b1 && lat < 40) begin
      @(negedge clk_i);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: busy=%b done=%b, required 0 0", busy_o, done_o);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (x_obs[i] !== 10'd0) begin
        errors++;
        $display("[TB] FAIL reset_x%0d: got %0d, required 0", i, x_obs[i]);
      end
    end
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_half_weights;
    int lat;
    write_all(8'h80);
    feat_i  = 16'h4321;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_after_start: got %b, required 1", busy_o);
    end
    lat = 0;
    while (done_o !== 1'b1 && lat < 40) begin
      @(negedge clk_i);
      lat++;
    end
    checks++;
    if (lat !== 32) begin
      errors++;
      $display("[TB] FAIL latency: got %0d, required 32", lat);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_at_done: got %b, required 0", busy_o);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (x_obs[i] !== 10'd160) begin
        errors++;
        $display("[TB] FAIL half_x%0d: got %0d, required 160", i, x_obs[i]);
      end
    end
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_width: got %b one cycle later, required 0", done_o);
    end
  endtask

  task automatic test_saturation;
    int lat;
    write_all(8'hFF);
    run_once(16'hFFFF, lat);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (x_obs[i] !== 10'd1023) begin
        errors++;
        $display("[TB] FAIL sat_x%0d: got %0d, required 1023", i, x_obs[i]);
      end
    end
    write_all(8'h11);
    run_once(16'hFFFF, lat);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (x_obs[i] !== 10'd127) begin
        errors++;
        $display("[TB] FAIL w11_x%0d: got %0d, required 127", i, x_obs[i]);
      end
    end
  endtask

  task automatic test_single_neuron;
    int lat;
    bit hold_bad;
    write_all(8'h00);
    write_w(5'd22, 8'h40);
    feat_i  = 16'h0800;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    hold_bad = 1'b0;
    lat = 0;
    while (done_o !== 1'b1 && lat < 40) begin
      for (int i = 0; i < 8; i++) if (x_obs[i] !== 10'd127) hold_bad = 1'b1;
      @(negedge clk_i);
      lat++;
    end
    checks++;
    if (hold_bad) begin
      errors++;
      $display("[TB] FAIL hold_during_run: outputs changed before done, required 127 held");
    end
    checks++;
    if (lat !== 32) begin
      errors++;
      $display("[TB] FAIL single_latency: got %0d, required 32", lat);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (x_obs[i] !== ((i == 5) ? 10'd64 : 10'd0)) begin
        errors++;
        $display("[TB] FAIL single_x%0d: got %0d, required %0d", i, x_obs[i], (i == 5) ? 64 : 0);
      end
    end
  endtask

  task automatic test_ignore_during_run;
    int done_cnt;
    int first;
    int lat;
    feat_i  = 16'h0801;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i  = 1'b0;
    done_cnt = 0;
    first    = 0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 10) start_i = 1'b1;
      if (c == 11) start_i = 1'b0;
      if (c == 12) begin
        wr_en_i   = 1'b1;
        wr_addr_i = 5'd0;
        wr_data_i = 8'hFF;
      end
      if (c == 13) wr_en_i = 1'b0;
      @(negedge clk_i);
      if (done_o === 1'b1) begin
        done_cnt++;
        if (first == 0) first = c;
      end
    end
    checks++;
    if (done_cnt !== 1 || first !== 32) begin
      errors++;
      $display("[TB] FAIL restart_ignored: %0d done pulses first at %0d, required 1 at 32", done_cnt, first);
    end
    checks++;
    if (x0 !== 10'd0 || x5 !== 10'd64) begin
      errors++;
      $display("[TB] FAIL ignore_vals: x0=%0d x5=%0d, required 0 64", x0, x5);
    end
    run_once(16'h0801, lat);
    checks++;
    if (x0 !== 10'd0 || x5 !== 10'd64) begin
      errors++;
      $display("[TB] FAIL dropped_write: x0=%0d x5=%0d, required 0 64", x0, x5);
    end
  endtask

  task automatic test_reset_mid_run;
    int done_cnt;
    int lat;
    feat_i  = 16'h0800;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (14) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_mid_run: got %b, required 1", busy_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || x5 !== 10'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: busy=%b done=%b x5=%0d, required 0 0 0", busy_o, done_o, x5);
    end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    done_cnt = 0;
    repeat (30) begin
      @(negedge clk_i);
      if (done_o === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL no_done_after_reset: got %0d pulses, required 0", done_cnt);
    end
    run_once(16'hFFFF, lat);
    checks++;
    if (lat !== 32) begin
      errors++;
      $display("[TB] FAIL post_reset_latency: got %0d, required 32", lat);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (x_obs[i] !== 10'd0) begin
        errors++;
        $display("[TB] FAIL zero_w_x%0d: got %0d, required 0", i, x_obs[i]);
      end
    end
  endtask

  task automatic test_write_and_start;
    int lat;
    feat_i    = 16'h0002;
    wr_en_i   = 1'b1;
    wr_addr_i = 5'd0;
    wr_data_i = 8'h80;
    start_i   = 1'b1;
    @(negedge clk_i);
    wr_en_i = 1'b0;
    start_i = 1'b0;
    lat = 0;
    while (done_o !== 1'b1 && lat < 40) begin
      @(negedge clk_i);
      lat++;
    end
    checks++;
    if (lat !== 32) begin
      errors++;
      $display("[TB] FAIL ws_latency: got %0d, required 32", lat);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (x_obs[i] !== ((i == 0) ? 10'd32 : 10'd0)) begin
        errors++;
        $display("[TB] FAIL ws_x%0d: got %0d, required %0d", i, x_obs[i], (i == 0) ? 32 : 0);
      end
    end
  endtask

  initial begin
    rst_i     = 1'b0;
    start_i   = 1'b0;
    feat_i    = 16'h0000;
    wr_en_i   = 1'b0;
    wr_addr_i = 5'd0;
    wr_data_i = 8'h00;
    test_reset();
    test_half_weights();
    test_saturation();
    test_single_neuron();
    test_ignore_during_run();
    test_reset_mid_run();
    test_write_and_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hidden_layer_seq.md
Name: hidden_layer_seq

Overview:
Hidden-layer stage directly upstream of the output neuron. Computes 8 hidden activations x0..x7 (10-bit, Q6.4 unsigned) from 4 unsigned 4-bit input features and a 32-entry weight bank, using one time-multiplexed multiplier. On completion it presents a consistent x0..x7 set and pulses done_o, which drives the output neuron's en_i.

Parameters:
N_IN, 4, input features per hidden neuron (fixed; addressing depends on it)
FEAT_W, 4, feature width, unsigned integer
W_W, 8, weight width, unsigned 1.7 fixed point
X_W, 10, activation output width, unsigned Q6.4
ACC_W, 14, accumulator width (Q7.7)
SHIFT, 3, right shift from accumulator (7 frac bits) to output (4 frac bits)

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-low reset
start_i  input  1  request one forward computation
feat_i  input  16  features, f_k = feat_i[4k+3:4k], k=0..3
wr_en_i  input  1  weight write strobe
wr_addr_i  input  5  weight address = 4*j + k (neuron j, input k)
wr_data_i  input  8  weight value, 1.7 unsigned
busy_o  output  1  computation in progress
done_o  output  1  one-cycle pulse: x0_o..x7_o updated
x0_o..x7_o  output  10 each  hidden activations to output neuron

Behaviour:
- Reset (async, rst_i low): state IDLE; busy_o=0, done_o=0, all x*_o=0, all 32 weights=0, accumulator/counters=0.
- States: IDLE, RUN. In IDLE, start_i high at edge T -> RUN; feat_i latched into feature regs; step counter=0; accumulator=0.
- RUN: each edge T+1..T+32 performs one MAC for step s (0..31), j=s>>2, k=s&3: acc += f_k * w[4j+k] (12-bit product, zero-extended).
- At the step with k=3, the completed sum is converted and written to working reg xw_j; acc cleared for the next neuron.
- Conversion: v = acc >> SHIFT (11 bits); x = (v > 1023) ? 1023 : v. Unsigned saturation, no rounding.
- At edge T+32: xw0..xw7 copied to x0_o..x7_o simultaneously; done_o=1 for exactly the following cycle; state -> IDLE.
- busy_o high from after edge T through after edge T+32 (registered, equal to state==RUN). Latency start->done = 32 cycles; next start is accepted at edge T+33 at the earliest.
- x*_o hold their value between runs; never partially updated.
- start_i while RUN: ignored (no restart, no queueing).
- wr_en_i in IDLE: w[wr_addr_i] <= wr_data_i at that edge. wr_en_i while RUN: dropped, bank unchanged.
- wr_en_i and start_i in the same IDLE edge: write completes first; the run uses the new weight.
- feat_i changes during RUN: no effect (latched copy used).
- Reset mid-RUN: immediate return to IDLE, done_o never pulses, x*_o=0, weights=0.
- Counter wrap: step counter is 5 bits; step 31 ends the run and is never followed by step 0 in the same run.

Decomposition:
- Shared package nn_pkg: FEAT_W, W_W, X_W, ACC_W, SHIFT, N_IN, N_HID=8; saturating-shift function sat_shift(acc) -> X_W; state enum {IDLE, RUN}. Output neuron reuses X_W and W_W from it.
- One sub-module: mac_unit (registered 4x8 multiply + ACC_W accumulate with clear and enable). FSM, weight bank, and output registers stay in hidden_layer_seq.

Test Plan:
- Write all 32 weights 0x80, feat = {4,3,2,1} (f0=1..f3=4), start -> done_o exactly 32 cycles after start edge; every x_j = (10*128)>>3 = 160.
- Weights all 0xFF, features all 15 -> acc 15300, v=1912 -> every x_j = 1023 (saturated); weights 0x11, features all 15 -> acc 1020 -> x=127.
- Only w[22]=0x40 (j=5,k=2), f2=8, others 0 -> x5_o=64, all other x = 0; x*_o unchanged until the done cycle.
- start_i pulsed again at cycle 10 of a run and wr_en_i to addr 0 during the run -> single done_o at cycle 32; weight 0 readback via a second run shows old value.
- Assert rst_i low at cycle 15 of a run -> busy_o=0 immediately, no done_o, x*_o=0; after release a fresh run with zero weights gives all x=0.
- Write w[0]=0x80 and start on the same edge with f0=2 -> x0_o=32 (new weight used).
